func_unit: RTL and testbench
============================

FUNC_UNIT -- requirements
Module: func_unit

Interface
- REQ-001: clk  input  1  sole clock; all state updates on rising edge.
- REQ-002: rst  input  1  reset, synchronous, active-high.
- REQ-003: A  input  32  operand A from register-file read port SA.
- REQ-004: B  input  32  operand B from register-file read port SB.
- REQ-005: FS  input  4  function select: 0 PASSA, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SLL, 7 SRL, 8 MUL, 9-15 illegal.
- REQ-006: DA_in  input  5  destination register address for the result.
- REQ-007: start  input  1  request; sampled only in IDLE.
- REQ-008: D  output  32  write-back data to register-file D port.
- REQ-009: DA  output  5  write-back address to register-file DA port.
- REQ-010: W  output  1  write enable to register file; one-cycle pulse.
- REQ-011: busy  output  1  high while an operation is in progress.
- REQ-012: done  output  1  one-cycle completion pulse, including suppressed writes.
- REQ-013: V, C, N, Z  output  1 each  overflow, carry, negative and zero flags of the last completed operation.

Function
- REQ-014: FSM states SHALL be IDLE, MUL, WB.
- REQ-015: In IDLE with start=1, A, B, FS and DA_in SHALL be captured into internal registers.
- REQ-016: After capture, FS!=8 SHALL go to WB; FS=8 SHALL go to MUL with the iteration counter at 0.
- REQ-017: Single-cycle latency: start sampled at edge t gives W/done high during the cycle after edge t+1.
- REQ-018: MUL SHALL run an unsigned shift-add, one multiplier bit per cycle, for exactly 32 cycles, then go to WB; D = low 32 bits of A*B; start-to-done = 33 cycles.
- REQ-019: WB SHALL last one cycle, assert done=1, drive D/DA, and return to IDLE.
- REQ-020: busy SHALL be 1 in MUL and WB and 0 in IDLE; start while busy SHALL be ignored, not queued.
- REQ-021: ADD/SUB SHALL be 32-bit modulo; C = carry-out (SUB: C=1 means no borrow, A+~B+1); V = two's-complement overflow.
- REQ-022: SLL/SRL SHALL shift A logically by B[4:0]; B[31:5] SHALL be ignored.
- REQ-023: For non-arith ops, C=0 and V=0; for MUL, C=1 when the high product word is nonzero and V=0.
- REQ-024: N = D[31] and Z = (D==0) SHALL update at WB; all flags SHALL hold until the next WB.
- REQ-025: W SHALL be 1 in WB only when DA != 31 and FS is legal; register 31 reads as zero and SHALL never be written.
- REQ-026: Illegal FS SHALL complete through WB with D=0, W=0, done=1, flags unchanged.
- REQ-027: Outside WB, W and done SHALL be 0; D and DA SHALL hold their last WB values.

Reset
- REQ-028: rst=1 at an edge SHALL force IDLE and clear D, DA, W, done, busy, V, C, N, Z, the counter and captured operands to 0, overriding start.
- REQ-029: rst during MUL SHALL abort the operation with no W or done pulse.

Configuration
- REQ-030: Macro FUNC_UNIT_MUL_EN SHALL gate the multiplier; when defined, FS=8 behaves per REQ-018.
- REQ-031: When FUNC_UNIT_MUL_EN is undefined, no multiplier or MUL state SHALL be built, FS=8 SHALL be illegal per REQ-026, and busy SHALL never exceed one cycle.

Verification
- REQ-032: ADD A=0x7FFFFFFF, B=1, DA_in=5 -> next cycle W=1, DA=5, D=0x80000000, V=1, N=1, C=0, Z=0.
- REQ-033: SUB A=5, B=5, DA_in=3 -> D=0, Z=1, C=1, V=0, W=1 one cycle after start.
- REQ-034: MUL A=0x00010000, B=0x00010000 (MUL_EN defined) -> busy for 33 cycles, done at cycle 33, D=0, C=1, Z=1; start pulses mid-operation ignored.
- REQ-035: ADD A=1, B=2, DA_in=31 -> done=1, W=0, D=3.
- REQ-036: MUL A=3, B=7, rst asserted at cycle 10 -> no done or W, all outputs 0, next ADD completes normally.
- REQ-037: FS=12, and FS=8 with MUL_EN undefined -> done=1 after 1 cycle, W=0, D=0, flags unchanged.

Source files
------------

// File: rtl/func_unit.sv
// Register-file function unit: single-cycle ALU/shifter with an optional 32-cycle shift-add multiplier.
// Build option: define FUNC_UNIT_MUL_EN to include the multiplier (FS=8); otherwise FS=8 is illegal.
module func_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  FS,
    input  logic [4:0]  DA_in,
    input  logic        start,
    output logic [31:0] D,
    output logic [4:0]  DA,
    output logic        W,
    output logic        busy,
    output logic        done,
    output logic        V,
    output logic        C,
    output logic        N,
    output logic        Z,
    output logic [1:0]  dbg_state_o
);

    // Handshake: start is a request sampled only while busy=0; done pulses once per accepted request.
`ifdef FUNC_UNIT_MUL_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WB = 2'd1, S_MUL = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WB = 2'd1} state_t;
`endif

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [3:0]  fs_q, fs_d;
    logic [4:0]  da_q, da_d;
    logic [31:0] d_q, d_d;
    logic [4:0]  dout_q, dout_d;
    logic        w_q, w_d, done_q, done_d;
    logic        v_q, v_d, c_q, c_d, n_q, n_d, z_q, z_d;
`ifdef FUNC_UNIT_MUL_EN
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] prod_q, prod_d;
    logic [32:0] mul_sum;
`endif

    logic [32:0] add_s, sub_s;
    logic [31:0] res;
    logic        res_c, res_v, legal;

    always_comb begin
        add_s = {1'b0, a_q} + {1'b0, b_q};
        sub_s = {1'b0, a_q} + {1'b0, ~b_q} + 33'd1;
        res   = 32'd0;
        res_c = 1'b0;
        res_v = 1'b0;
        legal = 1'b1;
        case (fs_q)
            4'd0: res = a_q;
            4'd1: begin
                res   = add_s[31:0];
                res_c = add_s[32];
                res_v = (a_q[31] == b_q[31]) && (add_s[31] != a_q[31]);
            end
            4'd2: begin
                res   = sub_s[31:0];
                res_c = sub_s[32];
                res_v = (a_q[31] != b_q[31]) && (sub_s[31] != a_q[31]);
            end
            4'd3: res = a_q & b_q;
            4'd4: res = a_q | b_q;
            4'd5: res = a_q ^ b_q;
            4'd6: res = a_q << b_q[4:0];
            4'd7: res = a_q >> b_q[4:0];
`ifdef FUNC_UNIT_MUL_EN
            4'd8: begin
                res   = prod_q[31:0];
                res_c = |prod_q[63:32];
            end
`endif
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        fs_d    = fs_q;
        da_d    = da_q;
        d_d     = d_q;
        dout_d  = dout_q;
        w_d     = 1'b0;
        done_d  = 1'b0;
        v_d     = v_q;
        c_d     = c_q;
        n_d     = n_q;
        z_d     = z_q;
`ifdef FUNC_UNIT_MUL_EN
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        mul_sum = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, a_q} : 33'd0);
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    fs_d    = FS;
                    da_d    = DA_in;
                    state_d = S_WB;
`ifdef FUNC_UNIT_MUL_EN
                    if (FS == 4'd8) begin
                        state_d = S_MUL;
                        cnt_d   = 5'd0;
                        prod_d  = {32'd0, B};
                    end
`endif
                end
            end
`ifdef FUNC_UNIT_MUL_EN
            // Multiplier bits enter at prod[0]; partial sums accumulate in the upper half and shift down.
            S_MUL: begin
                prod_d = {mul_sum, prod_q[31:1]};
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = S_WB;
            end
`endif
            S_WB: begin
                done_d  = 1'b1;
                dout_d  = da_q;
                state_d = S_IDLE;
                if (legal) begin
                    d_d = res;
                    w_d = (da_q != 5'd31);
                    v_d = res_v;
                    c_d = res_c;
                    n_d = res[31];
                    z_d = (res == 32'd0);
                end else begin
                    d_d = 32'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            fs_q    <= 4'd0;
            da_q    <= 5'd0;
            d_q     <= 32'd0;
            dout_q  <= 5'd0;
            w_q     <= 1'b0;
            done_q  <= 1'b0;
            v_q     <= 1'b0;
            c_q     <= 1'b0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
`ifdef FUNC_UNIT_MUL_EN
            cnt_q   <= 5'd0;
            prod_q  <= 64'd0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            fs_q    <= fs_d;
            da_q    <= da_d;
            d_q     <= d_d;
            dout_q  <= dout_d;
            w_q     <= w_d;
            done_q  <= done_d;
            v_q     <= v_d;
            c_q     <= c_d;
            n_q     <= n_d;
            z_q     <= z_d;
`ifdef FUNC_UNIT_MUL_EN
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
`endif
        end
    end

    assign D           = d_q;
    assign DA          = dout_q;
    assign W           = w_q;
    assign done        = done_q;
    assign busy        = (state_q != S_IDLE);
    assign V           = v_q;
    assign C           = c_q;
    assign N           = n_q;
    assign Z           = z_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_func_unit.sv
// Directed bench for func_unit: ALU ops, flags, DA=31 suppression, illegal FS, multiplier or its absence, reset.
module tb_func_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a_r = '0, b_r = '0;
  logic [3:0]  fs_r = '0;
  logic [4:0]  da_r = '0;
  logic        start = 1'b0;
  logic [31:0] d_o;
  logic [4:0]  da_o;
  logic        w_o, busy_o, done_o, v_o, c_o, n_o, z_o;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  int cyc, bcnt, dcnt;

  func_unit dut (
    .clk(clk), .rst(rst), .A(a_r), .B(b_r), .FS(fs_r), .DA_in(da_r), .start(start),
    .D(d_o), .DA(da_o), .W(w_o), .busy(busy_o), .done(done_o),
    .V(v_o), .C(c_o), .N(n_o), .Z(z_o), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] flags();
    return {28'd0, v_o, c_o, n_o, z_o};
  endfunction

  // Called at a negedge. Returns edges from the sampling edge to done (0 on timeout) and busy cycles seen.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] fs,
                        input logic [4:0] da, input int poke_at, output int c_out, output int b_out);
    a_r = a; b_r = b; fs_r = fs; da_r = da; start = 1'b1;
    c_out = 0; b_out = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == poke_at) begin
        start = 1'b1; fs_r = 4'd1; a_r = 32'h1111_1111; b_r = 32'h2222_2222; da_r = 5'd9;
      end
      if (busy_o) b_out++;
      if (done_o) begin
        c_out = i;
        break;
      end
    end
  endtask

  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done_o || w_o) cnt++;
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_D", d_o, 32'd0);
    chk("rst_DA", {27'd0, da_o}, 32'd0);
    chk("rst_ctl", {29'd0, w_o, done_o, busy_o}, 32'd0);
    chk("rst_flags", flags(), 32'd0);

    run_op(32'h7FFF_FFFF, 32'd1, 4'd1, 5'd5, -1, cyc, bcnt);
    chk("add_ovf_lat", cyc, 32'd1);
    chk("add_ovf_busy", bcnt, 32'd1);
    chk("add_ovf_D", d_o, 32'h8000_0000);
    chk("add_ovf_DA_W", {26'd0, da_o, w_o}, {26'd0, 5'd5, 1'b1});
    chk("add_ovf_flags", flags(), 32'b1010);
    @(negedge clk);
    chk("add_ovf_after_ctl", {30'd0, w_o, done_o}, 32'd0);
    chk("add_ovf_hold_D", d_o, 32'h8000_0000);
    chk("add_ovf_hold_flags", flags(), 32'b1010);

    run_op(32'd5, 32'd5, 4'd2, 5'd3, -1, cyc, bcnt);
    chk("sub_eq_lat", cyc, 32'd1);
    chk("sub_eq_D", d_o, 32'd0);
    chk("sub_eq_W", {31'd0, w_o}, 32'd1);
    chk("sub_eq_flags", flags(), 32'b0101);

    run_op(32'd3, 32'd5, 4'd2, 5'd1, -1, cyc, bcnt);
    chk("sub_brw_D", d_o, 32'hFFFF_FFFE);
    chk("sub_brw_flags", flags(), 32'b0010);

    run_op(32'd1, 32'd2, 4'd1, 5'd31, -1, cyc, bcnt);
    chk("add_r31_done", {31'd0, done_o}, 32'd1);
    chk("add_r31_W", {31'd0, w_o}, 32'd0);
    chk("add_r31_D", d_o, 32'd3);
    chk("add_r31_flags", flags(), 32'b0000);

    run_op(32'hF0F0_F0F0, 32'hFF00_FF00, 4'd3, 5'd2, -1, cyc, bcnt);
    chk("and_D", d_o, 32'hF000_F000);
    chk("and_flags", flags(), 32'b0010);
    run_op(32'h1234_0000, 32'h0000_5678, 4'd4, 5'd2, -1, cyc, bcnt);
    chk("or_D", d_o, 32'h1234_5678);
    chk("or_flags", flags(), 32'b0000);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd5, 5'd2, -1, cyc, bcnt);
    chk("xor_D", d_o, 32'd0);
    chk("xor_flags", flags(), 32'b0001);
    run_op(32'd1, 32'hFFFF_FFE3, 4'd6, 5'd2, -1, cyc, bcnt);
    chk("sll_D", d_o, 32'd8);
    run_op(32'h8000_0000, 32'h0000_003F, 4'd7, 5'd2, -1, cyc, bcnt);
    chk("srl_D", d_o, 32'd1);
    run_op(32'hDEAD_BEEF, 32'd0, 4'd0, 5'd7, -1, cyc, bcnt);
    chk("pass_D", d_o, 32'hDEAD_BEEF);
    chk("pass_DA_W", {26'd0, da_o, w_o}, {26'd0, 5'd7, 1'b1});
    chk("pass_flags", flags(), 32'b0010);

    run_op(32'd1, 32'd1, 4'd12, 5'd4, -1, cyc, bcnt);
    chk("ill12_lat", cyc, 32'd1);
    chk("ill12_W", {31'd0, w_o}, 32'd0);
    chk("ill12_D", d_o, 32'd0);
    chk("ill12_flags", flags(), 32'b0010);

`ifdef FUNC_UNIT_MUL_EN
    run_op(32'h0001_0000, 32'h0001_0000, 4'd8, 5'd6, 5, cyc, bcnt);
    chk("mul_big_lat", cyc, 32'd33);
    chk("mul_big_busy", bcnt, 32'd33);
    chk("mul_big_D", d_o, 32'd0);
    chk("mul_big_W", {31'd0, w_o}, 32'd1);
    chk("mul_big_flags", flags(), 32'b0101);
    count_done(5, dcnt);
    chk("mul_poke_ignored", dcnt, 32'd0);

    run_op(32'd3, 32'd7, 4'd8, 5'd6, -1, cyc, bcnt);
    chk("mul_small_lat", cyc, 32'd33);
    chk("mul_small_D", d_o, 32'd21);
    chk("mul_small_flags", flags(), 32'b0000);

    a_r = 32'd3; b_r = 32'd7; fs_r = 4'd8; da_r = 5'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    count_done(9, dcnt);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_no_done_before", dcnt, 32'd0);
`else
    run_op(32'd3, 32'd7, 4'd8, 5'd6, -1, cyc, bcnt);
    chk("ill8_lat", cyc, 32'd1);
    chk("ill8_busy", bcnt, 32'd1);
    chk("ill8_W", {31'd0, w_o}, 32'd0);
    chk("ill8_D", d_o, 32'd0);
    chk("ill8_flags", flags(), 32'b0010);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif
    chk("abort_D", d_o, 32'd0);
    chk("abort_DA", {27'd0, da_o}, 32'd0);
    chk("abort_ctl", {29'd0, w_o, done_o, busy_o}, 32'd0);
    chk("abort_flags", flags(), 32'd0);
    count_done(40, dcnt);
    chk("abort_no_done_after", dcnt, 32'd0);

    run_op(32'd1, 32'd2, 4'd1, 5'd8, -1, cyc, bcnt);
    chk("post_rst_lat", cyc, 32'd1);
    chk("post_rst_D", d_o, 32'd3);
    chk("post_rst_DA_W", {26'd0, da_o, w_o}, {26'd0, 5'd8, 1'b1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
